// File: rtl/simd_writeback.sv
// SIMD writeback queue: buffers 4xFP32 ALU results and drains them to the VRF.
// Define FLUX_WB_LANE_MASK_EN to carry per-lane write masks through the queue.
module simd_writeback #(
    parameter int DEPTH = 4,
    parameter int DST_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [127:0]     alu_result,
    input  logic [DST_W-1:0] alu_dst,
    input  logic [3:0]       alu_lane_mask,
    output logic             issue_stall,
    output logic             rf_wr_valid,
    input  logic             rf_wr_ready,
    output logic [DST_W-1:0] rf_wr_addr,
    output logic [127:0]     rf_wr_data,
    output logic [3:0]       rf_wr_mask,
    output logic             overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [127:0]     data_q [DEPTH];
    logic [DST_W-1:0] dst_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = !empty && rf_wr_ready;
    assign push  = alu_valid && (!full || pop);
    assign drop  = alu_valid && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case (1'b1)
                push && !pop: count <= count + CNT_W'(1);
                pop && !push: count <= count - CNT_W'(1);
                default:      count <= count;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; the outputs are gated while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= alu_result;
            dst_q[wr_ptr]  <= alu_dst;
        end
    end

`ifdef FLUX_WB_LANE_MASK_EN
    logic [3:0] mask_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mask_q[wr_ptr] <= alu_lane_mask;
        end
    end

    assign rf_wr_mask = empty ? 4'h0 : mask_q[rd_ptr];
`else
    logic unused_lane_mask;

    assign unused_lane_mask = ^alu_lane_mask;
    assign rf_wr_mask       = 4'hF;
`endif

    assign rf_wr_valid  = !empty;
    assign rf_wr_addr   = empty ? '0 : dst_q[rd_ptr];
    assign rf_wr_data   = empty ? '0 : data_q[rd_ptr];
    // One slot stays free for the result already inside the ALU.
    assign issue_stall  = (count >= CNT_W'(DEPTH - 1));
    assign overflow_err = overflow_q;

endmodule

// File: doc/simd_writeback.md
SIMD_WRITEBACK -- requirements
Module: simd_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter DST_W, default 4, destination vector-register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port alu_valid  input  1  SIMD ALU result valid this cycle (push request).
REQ-006 SHALL have port alu_result  input  128  4x FP32 result, lane0 in [31:0].
REQ-007 SHALL have port alu_dst  input  DST_W  destination register, aligned with alu_valid.
REQ-008 SHALL have port alu_lane_mask  input  4  per-lane write enables, aligned with alu_valid (used only under REQ-030).
REQ-009 SHALL have port issue_stall  output  1  tells the issue stage to stop enabling the ALU.
REQ-010 SHALL have port rf_wr_valid  output  1  register-file write request.
REQ-011 SHALL have port rf_wr_ready  input  1  register file accepts write.
REQ-012 SHALL have port rf_wr_addr  output  DST_W  write address.
REQ-013 SHALL have port rf_wr_data  output  128  write data.
REQ-014 SHALL have port rf_wr_mask  output  4  lane write mask.
REQ-015 SHALL have port overflow_err  output  1  sticky overflow flag.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH entries {result, dst, mask}, with read/write pointers and an occupancy count of width log2(DEPTH)+1.
REQ-017 SHALL push an entry on a rising edge when alu_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-018 SHALL pop on a rising edge when rf_wr_valid=1 and rf_wr_ready=1, i.e. a handshake.
REQ-019 SHALL drive rf_wr_valid=1 whenever count>0, with rf_wr_addr/data/mask taken from the head entry. No bypass: data becomes visible the cycle after push.
REQ-020 SHALL hold rf_wr_addr/data/mask and rf_wr_valid stable while rf_wr_valid=1 and rf_wr_ready=0.
REQ-021 SHALL handle simultaneous push and pop by leaving count unchanged and advancing both pointers, including at count=DEPTH and count=1.
REQ-022 SHALL wrap pointers modulo DEPTH.
REQ-023 SHALL assert issue_stall combinationally when count >= DEPTH-1, reserving one slot for the result already inside the 1-cycle ALU.
REQ-024 SHALL drop the push when alu_valid=1, count=DEPTH and there is no pop; the FIFO is unchanged and overflow_err sets to 1 and holds until reset.
REQ-025 SHALL ignore rf_wr_ready when count=0 and change no state.
REQ-026 SHALL leave pushed data unmodified; it performs no FP interpretation.

Reset
REQ-027 SHALL, when rst_n=0, asynchronously clear count, pointers and overflow_err to 0.
REQ-028 SHALL, during and after reset, drive rf_wr_valid=0 and issue_stall=0; rf_wr_addr, rf_wr_data and rf_wr_mask read 0 while the FIFO is empty after reset.
REQ-029 SHALL discard all queued entries on a mid-operation reset; the first write after release is the first post-reset push.

Configuration
REQ-030 SHALL, when FLUX_WB_LANE_MASK_EN is defined, store alu_lane_mask per entry and output it on rf_wr_mask.
REQ-031 SHALL, when FLUX_WB_LANE_MASK_EN is undefined, ignore alu_lane_mask, store no mask bits, and tie rf_wr_mask to 4'hF.

Verification
REQ-032 SHALL verify this scenario: reset, push dst=3 result=0x3F800000 x4, rf_wr_ready=1 -> next cycle rf_wr_valid=1, addr=3, data matches; count returns to 0.
REQ-033 SHALL verify this scenario: rf_wr_ready=0, push 3 entries -> issue_stall=1 once count=3; entries drain in push order when ready=1.
REQ-034 SHALL verify this scenario: fill to 4 with ready=0, push 5th -> overflow_err=1, head unchanged, only 4 writes emerge.
REQ-035 SHALL verify this scenario: count=4, alu_valid=1 and ready=1 same cycle -> no overflow, count stays 4, new entry written last.
REQ-036 SHALL verify this scenario: 10 back-to-back pushes with ready toggling 1/0 -> all 10 written in order, pointer wrap exercised, no loss.
REQ-037 SHALL verify this scenario: rst_n=0 with 2 entries queued -> rf_wr_valid=0 immediately, overflow_err=0, no stale writes after release; with FLUX_WB_LANE_MASK_EN, mask 4'b0101 appears on rf_wr_mask, without it 4'hF.
